mem_playback: RTL and testbench

Parametrised successor to the fixed-pattern RAM demo top. The block loads a run-time-length sequence of words into an internal synchronous single-port RAM through a valid/ready stream. It then plays the sequence back one word per programmable tick period, in loop or one-shot mode, and drives LED/display logic or any downstream consumer.

---
 rtl/mem_playback_pkg.sv | 19 +
 rtl/spram_sync.sv | 24 ++
 rtl/mem_playback.sv | 183 ++++++++++++++++++
 tb/tb_mem_playback.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_playback_pkg.sv
// rtl/mem_playback_pkg.sv - shared state encoding, default widths and walking-pattern helper for mem_playback
package mem_playback_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    INIT = 2'd3
  } state_t;

  // Word idx of the self-running demo pattern: a single bit stepping by 4 positions.
  function automatic logic [63:0] walk_word(input int idx, input int data_w);
    return 64'd1 << ((4 * idx) % data_w);
  endfunction

endpackage

// File: rtl/spram_sync.sv
// rtl/spram_sync.sv - single-port synchronous RAM with one-cycle registered read, no reset on contents
module spram_sync
  import mem_playback_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    dout <= r_mem[addr];
  end

endmodule

// File: rtl/mem_playback.sv
// rtl/mem_playback.sv - stream-loaded RAM sequence played back one word per tick; WALK_INIT_EN adds a self-loading demo INIT state
module mem_playback
  import mem_playback_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              play_en,
  input  logic              loop_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] play_idx,
  output logic              done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t r_state, w_next;

  logic [LEN_W-1:0]  r_len, r_waddr, r_rd_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_tick_d1;
  logic [ADDR_W-1:0] r_idx_d1;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic [ADDR_W-1:0] r_play_idx;
  logic              r_done;
`ifdef WALK_INIT_EN
  logic [1:0]        r_init_idx;
`endif

  logic              w_start, w_wr, w_last_wr, w_tick, w_present, w_finish;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, w_ram_q;

  assign w_start   = load_start && (load_len != '0) && ((r_state == IDLE) || (r_state == PLAY));
  assign w_wr      = (r_state == LOAD) && din_valid;
  assign w_last_wr = w_wr && (r_waddr == r_len - LEN_ONE);
  // rd_idx stops at len after a one-shot pass, which blocks further ticks.
  assign w_tick    = (r_state == PLAY) && play_en && (r_cnt == TICK_MAX) && (r_rd_idx < r_len) && !w_start;
  // An abort drops a read still in flight so dout keeps its last value.
  assign w_present = r_tick_d1 && !w_start;
  assign w_finish  = (r_state == PLAY) && w_present && (r_rd_idx == r_len);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
`ifdef WALK_INIT_EN
      r_state <= INIT;
`else
      r_state <= IDLE;
`endif
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = LOAD;
      LOAD: if (w_last_wr) w_next = PLAY;
      PLAY: begin
        if (w_start)       w_next = LOAD;
        else if (w_finish) w_next = IDLE;
      end
      INIT: begin
`ifdef WALK_INIT_EN
        if (r_init_idx == 2'd3) w_next = PLAY;
`else
        w_next = IDLE;
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    din_ready = 1'b0;
    w_we      = 1'b0;
    w_addr    = r_rd_idx[ADDR_W-1:0];
    w_wdata   = din;
    case (r_state)
      LOAD: begin
        din_ready = 1'b1;
        w_we      = din_valid;
        w_addr    = r_waddr[ADDR_W-1:0];
      end
      INIT: begin
`ifdef WALK_INIT_EN
        w_we    = 1'b1;
        w_addr  = ADDR_W'(r_init_idx);
        w_wdata = DATA_W'(walk_word(int'(r_init_idx), DATA_W));
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_len        <= '0;
      r_waddr      <= '0;
      r_rd_idx     <= '0;
      r_cnt        <= '0;
      r_tick_d1    <= 1'b0;
      r_idx_d1     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_play_idx   <= '0;
      r_done       <= 1'b0;
`ifdef WALK_INIT_EN
      r_init_idx   <= '0;
`endif
    end else begin
      if (w_start) begin
        r_len   <= load_len;
        r_waddr <= '0;
        r_done  <= 1'b0;
      end else if (w_wr) begin
        r_waddr <= r_waddr + LEN_ONE;
      end

      if ((r_state != PLAY) || w_start) begin
        r_cnt <= '0;
      end else if (play_en) begin
        r_cnt <= (r_cnt == TICK_MAX) ? '0 : r_cnt + CNT_W'(1);
      end

      if (r_state != PLAY) begin
        r_rd_idx <= '0;
      end else if (w_tick) begin
        r_rd_idx <= ((r_rd_idx == r_len - LEN_ONE) && loop_en) ? '0 : r_rd_idx + LEN_ONE;
      end

      r_tick_d1    <= w_tick;
      r_idx_d1     <= r_rd_idx[ADDR_W-1:0];
      r_dout_valid <= w_present;
      if (w_present) begin
        r_dout     <= w_ram_q;
        r_play_idx <= r_idx_d1;
      end
      if (w_finish) begin
        r_done <= 1'b1;
      end

`ifdef WALK_INIT_EN
      if (r_state == INIT) begin
        r_init_idx <= r_init_idx + 2'd1;
        if (r_init_idx == 2'd3) r_len <= LEN_W'(4);
      end
`endif
    end
  end

  spram_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK  (CLK),
    .we   (w_we),
    .addr (w_addr),
    .din  (w_wdata),
    .dout (w_ram_q)
  );

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign play_idx   = r_play_idx;
  assign done       = r_done;

endmodule

// File: tb/tb_mem_playback.sv
// tb/tb_mem_playback.sv - directed self-checking bench for mem_playback with TICK_DIV=4
module tb_mem_playback;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 9;
  localparam int TICK_DIV = 4;

  logic              CLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              play_en = 1'b1;
  logic              loop_en = 1'b1;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W-1:0] play_idx;
  logic              done;

  mem_playback #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .play_en    (play_en),
    .loop_en    (loop_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .play_idx   (play_idx),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [DATA_W-1:0] q_data [$];
  int                q_idx  [$];
  int                q_cyc  [$];

  always @(negedge CLK) begin
    if (rst_n && dout_valid) begin
      q_data.push_back(dout);
      q_idx.push_back(int'(play_idx));
      q_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] stim [0:511];
  logic [DATA_W-1:0] held;
  int n0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_idx.delete();
    q_cyc.delete();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check("pulse_count_reached", 32'(q_data.size() >= n), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_din_ready"}, 32'(din_ready), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_play_idx"}, 32'(play_idx), 32'd0);
  endtask

`ifndef WALK_INIT_EN
  task automatic do_load(input int len, input bit gaps);
    int  i = 0;
    int  budget = 0;
    bit  fire;
    load_start = 1'b1;
    load_len   = len[ADDR_W:0];
    step(1);
    load_start = 1'b0;
    load_len   = '0;
    while (i < len && budget < 4 * len + 20) begin
      din_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      din       = stim[i];
      fire      = din_valid && din_ready;
      step(1);
      if (fire) i++;
      budget++;
    end
    din_valid = 1'b0;
    check("load_complete", 32'(i), 32'(len));
  endtask
`endif

  initial begin
    step(3);
    check_idle_outputs("reset0");
    rst_n = 1'b1;

`ifdef WALK_INIT_EN
    loop_en = 1'b1;
    wait_pulses(5, 100);
    for (int k = 0; k < 5; k++) begin
      check("walk_data", 32'(q_data[k]), 32'h1 << (4 * (k % 4)));
      check("walk_idx", 32'(q_idx[k]), 32'(k % 4));
    end
`else
    step(20);
    check("idle_no_pulse", 32'(q_data.size()), 32'd0);

    // loop playback, 4 words
    stim[0] = 16'h0001; stim[1] = 16'h0010; stim[2] = 16'h0100; stim[3] = 16'h1000;
    loop_en = 1'b1;
    clear_q();
    do_load(4, 1'b0);
    check("ready_low_after_load", 32'(din_ready), 32'd0);
    wait_pulses(5, 60);
    for (int k = 0; k < 5; k++) begin
      check("loop_data", 32'(q_data[k]), 32'(stim[k % 4]));
      check("loop_idx", 32'(q_idx[k]), 32'(k % 4));
    end
    for (int k = 0; k < 4; k++) check("loop_period", 32'(q_cyc[k+1] - q_cyc[k]), 32'd4);

    // reset while playing
    rst_n = 1'b0;
    #2;
    check_idle_outputs("reset_mid_play");
    step(2);
    rst_n = 1'b1;
    clear_q();
    step(20);
    check("post_reset_no_pulse", 32'(q_data.size()), 32'd0);

    // one-shot, 3 words
    stim[0] = 16'h00A1; stim[1] = 16'h00B2; stim[2] = 16'h00C3;
    loop_en = 1'b0;
    clear_q();
    do_load(3, 1'b0);
    step(40);
    check("oneshot_pulses", 32'(q_data.size()), 32'd3);
    for (int k = 0; k < 3; k++) check("oneshot_data", 32'(q_data[k]), 32'(stim[k]));
    check("oneshot_done", 32'(done), 32'd1);
    check("oneshot_dout_held", 32'(dout), 32'h00C3);
    check("oneshot_ready_idle", 32'(din_ready), 32'd0);

    // zero-length load is ignored
    load_start = 1'b1;
    load_len   = '0;
    step(1);
    load_start = 1'b0;
    check("len0_ready", 32'(din_ready), 32'd0);
    check("len0_done_kept", 32'(done), 32'd1);
    step(10);
    check("len0_no_pulse", 32'(q_data.size()), 32'd3);

    // gapped stream, 8 words, looping
    for (int i = 0; i < 8; i++) stim[i] = 16'h1100 + 16'(i * 16'h0111);
    loop_en = 1'b1;
    clear_q();
    do_load(8, 1'b1);
    check("done_cleared_by_load", 32'(done), 32'd0);
    wait_pulses(8, 80);
    for (int k = 0; k < 8; k++) check("gap_data", 32'(q_data[k]), 32'(stim[k]));

    // freeze for 10 cycles right after a pulse
    n0 = q_data.size();
    wait_pulses(n0 + 1, 20);
    play_en = 1'b0;
    step(10);
    check("freeze_no_pulse", 32'(q_data.size()), 32'(n0 + 1));
    play_en = 1'b1;
    wait_pulses(n0 + 2, 30);
    check("freeze_period", 32'(q_cyc[n0+1] - q_cyc[n0]), 32'd14);

    // abort mid-play with a new 2-word sequence
    held = dout;
    stim[0] = 16'hAAAA; stim[1] = 16'h5555;
    clear_q();
    do_load(2, 1'b0);
    check("abort_dout_held", 32'(dout), 32'(held));
    check("abort_done", 32'(done), 32'd0);
    check("abort_no_stale_pulse", 32'(q_data.size()), 32'd0);
    wait_pulses(2, 30);
    check("abort_data0", 32'(q_data[0]), 32'hAAAA);
    check("abort_data1", 32'(q_data[1]), 32'h5555);

    // full-depth sequence wraps 511 -> 0
    for (int i = 0; i < 512; i++) stim[i] = 16'(i);
    clear_q();
    do_load(512, 1'b0);
    wait_pulses(513, 2200);
    check("full_idx_last", 32'(q_idx[511]), 32'd511);
    check("full_data_last", 32'(q_data[511]), 32'd511);
    check("full_idx_wrap", 32'(q_idx[512]), 32'd0);
    check("full_data_wrap", 32'(q_data[512]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
